// File: rtl/riscv_pkg.sv
// Shared fetch/control definitions: jump encodings, fetch FSM states, instruction width.
package riscv_pkg;

    localparam int unsigned INSTR_W = 32;

    localparam logic [1:0] J_NONE = 2'b00;
    localparam logic [1:0] J_JAL  = 2'b01;
    localparam logic [1:0] J_JALR = 2'b10;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH entries of {instr, pc} with push/pop/flush and occupancy count.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [INSTR_W-1:0] push_instr,
    input  logic [ADDR_W-1:0]  push_pc,
    output logic [INSTR_W-1:0] head_instr,
    output logic [ADDR_W-1:0]  head_pc,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [ADDR_W-1:0]  pc_mem    [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign do_push = push & ~flush;
    assign do_pop  = pop & ~flush & ~empty;
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));

    assign head_instr = instr_mem[rd_ptr];
    assign head_pc    = pc_mem[rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            instr_mem[wr_ptr] <= push_instr;
            pc_mem[wr_ptr]    <= push_pc;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues in-order imem reads, buffers returned words and
// hands {instr, pc, pc+4} to decode; branch/jump redirects flush and drain stale reads.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned      ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned      DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               PCSrc,
    input  logic [1:0]         J,
    input  logic [ADDR_W-1:0]  br_pc,
    input  logic [ADDR_W-1:0]  imm_ext,
    input  logic [ADDR_W-1:0]  jalr_target,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [ADDR_W-1:0]  instr_pc4
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t      state, state_next;
    logic [ADDR_W-1:0] pc, pc_next;
    logic [CNT_W-1:0]  inflight, inflight_next;
    logic [CNT_W-1:0]  drop, drop_next;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    occupancy;
    logic              issue_en;
    logic              fifo_full, fifo_empty;
    logic              push, pop, flush, rsp_drop;
    logic              redirect;
    logic [ADDR_W-1:0] target;
    logic              unused_jalr_lsb;

    assign redirect        = PCSrc | (J == J_JAL) | (J == J_JALR);
    assign target          = (J == J_JALR) ? {jalr_target[ADDR_W-1:1], 1'b0} : br_pc + imm_ext;
    assign unused_jalr_lsb = jalr_target[0];
    assign imem_req_addr   = pc;
    assign occupancy       = (CNT_W+1)'(inflight) + (CNT_W+1)'(fifo_count);

    // State register; issue_en holds off requests until the first edge after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            pc       <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
            issue_en <= 1'b0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            inflight <= inflight_next;
            drop     <= drop_next;
            issue_en <= 1'b1;
        end
    end

    // Next-state and handshake logic; a redirect overrides every other same-cycle event
    always_comb begin
        state_next     = state;
        pc_next        = pc;
        inflight_next  = inflight;
        drop_next      = drop;
        imem_req_valid = 1'b0;
        instr_valid    = 1'b0;
        push           = 1'b0;
        pop            = 1'b0;
        flush          = 1'b0;
        rsp_drop       = imem_rsp_valid && (drop != '0);

        if (imem_rsp_valid) inflight_next = inflight - CNT_W'(1);

        if (redirect) begin
            flush      = 1'b1;
            pc_next    = target;
            drop_next  = inflight_next;
            state_next = (inflight_next != '0) ? DRAIN : RUN;
        end else begin
            imem_req_valid = issue_en && (state == RUN) && !fifo_full
                             && (occupancy < (CNT_W+1)'(DEPTH));
            instr_valid    = !fifo_empty;
            pop            = instr_valid && instr_ready;
            push           = imem_rsp_valid && !rsp_drop;
            if (rsp_drop) drop_next = drop - CNT_W'(1);
            if (imem_req_valid && imem_req_ready) begin
                pc_next       = pc + ADDR_W'(4);
                inflight_next = inflight_next + CNT_W'(1);
            end
            if ((state == DRAIN) && (drop_next == '0)) state_next = RUN;
        end
    end

    fetch_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .flush      (flush),
        .push_instr (imem_rsp_data),
        .push_pc    (pc - ADDR_W'(4) * ADDR_W'(inflight)),
        .head_instr (instr),
        .head_pc    (instr_pc),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign instr_pc4 = instr_pc + ADDR_W'(4);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a variable-latency memory model and an in-order scoreboard.
module tb_fetch_unit;
    import riscv_pkg::*;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        PCSrc;
    logic [1:0]  J;
    logic [31:0] br_pc, imm_ext, jalr_target;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc, instr_pc4;

    int          n_pass = 0;
    int          n_total = 0;
    int          n_acc = 0;
    int          n_out = 0;
    logic        mem_stall = 1'b0;
    logic [31:0] exp_req = RST_PC;
    logic [31:0] last_out_pc = '0;
    logic [31:0] last_req_addr = '0;
    logic [31:0] mem_q[$];
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .PCSrc(PCSrc), .J(J), .br_pc(br_pc),
        .imm_ext(imm_ext), .jalr_target(jalr_target), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc), .instr_pc4(instr_pc4)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One clock: sample at negedge, update memory/scoreboard model, drive response after posedge
    task automatic step();
        logic        redir;
        logic [31:0] tgt, e;
        @(negedge clk);
        redir = rst_n && (PCSrc || (J == J_JAL) || (J == J_JALR));
        tgt   = (J == J_JALR) ? {jalr_target[31:1], 1'b0} : br_pc + imm_ext;
        if (redir) begin
            chk("redir_instr_valid", 32'(instr_valid), 32'd0);
            chk("redir_req_valid", 32'(imem_req_valid), 32'd0);
        end
        if (imem_rsp_valid && mem_q.size() > 0) void'(mem_q.pop_front());
        if (imem_req_valid && imem_req_ready) begin
            chk("req_addr", imem_req_addr, exp_req);
            mem_q.push_back(imem_req_addr);
            sb.push_back(imem_req_addr);
            exp_req       = exp_req + 32'd4;
            last_req_addr = imem_req_addr;
            n_acc++;
        end
        if (instr_valid && instr_ready) begin
            chk("sb_not_empty", 32'(sb.size() > 0), 32'd1);
            e = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
            chk("instr", instr, mem_word(e));
            chk("instr_pc", instr_pc, e);
            chk("instr_pc4", instr_pc4, e + 32'd4);
            last_out_pc = instr_pc;
            n_out++;
        end
        if (redir) begin
            sb.delete();
            exp_req = tgt;
        end
        @(posedge clk);
        #1;
        imem_rsp_valid = !mem_stall && (mem_q.size() > 0);
        imem_rsp_data  = imem_rsp_valid ? mem_word(mem_q[0]) : 32'h0;
    endtask

    task automatic wait_out(input string tag, input int bound);
        int n0 = n_out;
        for (int k = 0; k < bound && n_out == n0; k++) step();
        chk({tag, "_timeout"}, 32'(n_out != n0), 32'd1);
    endtask

    task automatic wait_req(input string tag, input int bound);
        int n0 = n_acc;
        for (int k = 0; k < bound && n_acc == n0; k++) step();
        chk({tag, "_timeout"}, 32'(n_acc != n0), 32'd1);
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock
    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        chk({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
        mem_q.delete();
        sb.delete();
        exp_req        = RST_PC;
        mem_stall      = 1'b0;
        imem_rsp_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] held, prev;
        int          base, n0;
        rst_n = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        PCSrc = 1'b0; J = J_NONE; br_pc = '0; imm_ext = '0; jalr_target = '0; instr_ready = 1'b1;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: sequential fetch from RESET_PC
        wait_req("t1_first_req", 10);
        chk("t1_first_addr", last_req_addr, RST_PC);
        repeat (16) step();
        chk("t1_progress", 32'(n_out >= 5), 32'd1);

        // 2: decode stall
        instr_ready = 1'b0;
        base = n_acc;
        repeat (10) step();
        chk("t2_reqs_le_depth", 32'((n_acc - base) <= DEPTH), 32'd1);
        chk("t2_req_valid_low", 32'(imem_req_valid), 32'd0);
        chk("t2_instr_valid", 32'(instr_valid), 32'd1);
        instr_ready = 1'b1;
        repeat (6) step();

        // 3: branch with two reads outstanding
        mem_stall = 1'b1; imem_rsp_valid = 1'b0;
        repeat (4) step();
        chk("t3_two_outstanding", 32'(mem_q.size()), 32'd2);
        chk("t3_req_blocked", 32'(imem_req_valid), 32'd0);
        PCSrc = 1'b1; br_pc = 32'h10; imm_ext = 32'hFFFF_FFF8;
        step();
        PCSrc = 1'b0;
        repeat (2) begin
            step();
            chk("t3_drain_no_req", 32'(imem_req_valid), 32'd0);
        end
        mem_stall = 1'b0;
        wait_out("t3_out", 20);
        chk("t3_next_pc", last_out_pc, 32'h08);
        repeat (4) step();

        // 4: JALR clears bit 0; J=11 is not a redirect
        J = J_JALR; jalr_target = 32'h101;
        step();
        J = J_NONE;
        wait_req("t4_req", 20);
        chk("t4_jalr_addr", last_req_addr, 32'h100);
        wait_out("t4_out", 20);
        prev = last_out_pc; n0 = n_out;
        J = 2'b11; PCSrc = 1'b0;
        step();
        J = J_NONE;
        if (n_out == n0) wait_out("t4_j11_out", 20);
        chk("t4_j11_no_redirect", last_out_pc, prev + 32'd4);
        repeat (4) step();

        // 5: memory backpressure holds the address; redirect during stall re-targets it
        imem_req_ready = 1'b0;
        repeat (2) step();
        held = imem_req_addr;
        chk("t5_valid_start", 32'(imem_req_valid), 32'd1);
        repeat (5) begin
            step();
            chk("t5_addr_stable", imem_req_addr, held);
            chk("t5_valid_held", 32'(imem_req_valid), 32'd1);
        end
        PCSrc = 1'b1; br_pc = 32'h200; imm_ext = 32'h40;
        step();
        PCSrc = 1'b0;
        step();
        chk("t5_retarget_valid", 32'(imem_req_valid), 32'd1);
        chk("t5_retarget_addr", imem_req_addr, 32'h240);
        imem_req_ready = 1'b1;
        repeat (8) step();

        // 6: async reset mid-run with buffered words, then mid-DRAIN
        instr_ready = 1'b0;
        repeat (6) step();
        chk("t6_setup_valid", 32'(instr_valid), 32'd1);
        async_reset("t6_run_rst");
        instr_ready = 1'b1;
        repeat (6) step();
        mem_stall = 1'b1; imem_rsp_valid = 1'b0;
        repeat (4) step();
        PCSrc = 1'b1; br_pc = 32'h40; imm_ext = 32'h0;
        step();
        PCSrc = 1'b0;
        step();
        async_reset("t6_drain_rst");
        wait_req("t6_restart", 20);
        chk("t6_restart_addr", last_req_addr, RST_PC);
        repeat (10) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
